// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and writeback request bundle for the
// register-file writeback arbiter.
package reg_wb_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic onehot0(input logic [1:0] v);
        return (v & (v - 2'd1)) == 2'b00;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_arb.sv
// Two-input writeback arbiter; round robin when WB_ROUND_ROBIN_EN
// is defined, otherwise the load requester wins every tie.
module wb_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef WB_ROUND_ROBIN_EN
    // 1 means requester 1 won the most recent transfer
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b11:   grant = 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback port arbiter, busy scoreboard and read-hazard detect.
// Tie policy selected by WB_ROUND_ROBIN_EN (see wb_rr_arb).
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              hazard,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [DATA_W-1:0] wr0_data,
    output logic [NREG-1:0]   busy
);

    wb_req_t     req [2];
    wb_req_t     sel;
    logic [1:0]  req_valid;
    logic [1:0]  grant;
    logic        xfer;
    logic        wr_en_q;
    logic [NREG-1:0] busy_nxt;

    assign req[REQ_ALU] = '{addr: req0_addr, data: req0_data};
    assign req[REQ_LD]  = '{addr: req1_addr, data: req1_data};

    // Reset masks requests so nothing is accepted while it is held
    assign req_valid[REQ_ALU] = req0_valid & ~rst;
    assign req_valid[REQ_LD]  = req1_valid & ~rst;

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LD];
    assign xfer       = |grant;

    always_comb begin
        sel = '0;
        unique case (1'b1)
            grant[REQ_ALU]: sel = req[REQ_ALU];
            grant[REQ_LD]:  sel = req[REQ_LD];
            default:        sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q  <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr0_addr <= sel.addr;
                wr0_data <= sel.data;
            end
        end
    end

    // A write still in flight when reset arrives never reaches the file
    assign wr_en = wr_en_q & ~rst;

    // Set is applied after clear so a fresh issue keeps the bit busy
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr0_addr] = 1'b0;
        end
        if (iss_valid) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hazard = busy[rd0_addr] | busy[rd1_addr];

    always_comb begin
        assert (onehot0(grant));
        assert ((grant & ~req_valid) == 2'b00);
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed scoreboard bench for reg_wb_arbiter.
// Expected writes are queued by stimulus and popped by a monitor.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr, rd0_addr, rd1_addr;
    logic              hazard, wr_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic [NREG-1:0]   busy;

    int errors = 0;
    int checks = 0;
    wb_req_t exp_q[$];

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .rd0_addr   (rd0_addr),
        .rd1_addr   (rd1_addr),
        .hazard     (hazard),
        .wr_en      (wr_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d);
        exp_q.push_back('{addr: a, data: d});
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every landed write must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got %0h:%0h expected none",
                         wr0_addr, wr0_data);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if ({wr0_addr, wr0_data} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL wr_data: got %0h:%0h expected %0h:%0h",
                             wr0_addr, wr0_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_g1;
`ifdef WB_ROUND_ROBIN_EN
        exp_g1 = 4'b1010;
`else
        exp_g1 = 4'b1111;
`endif
        // Reset with every input active
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1234;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h5678;
        iss_valid = 1'b1; iss_addr = 3'd4;
        rd0_addr = 3'd4; rd1_addr = 3'd4;
        @(negedge clk);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        check("rst_wr_en", wr_en, 0);
        next_cycle();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hazard", hazard, 0);
        check("rst_wr_en2", wr_en, 0);
        check("rst_wr_addr", wr0_addr, 0);
        check("rst_wr_data", wr0_data, 0);
        next_cycle();
        rst = 1'b0;
        iss_valid = 1'b0;
        rd0_addr = 3'd0; rd1_addr = 3'd0;
        req0_addr = 3'd1; req0_data = 16'h1111;
        req1_addr = 3'd2; req1_data = 16'h2222;

        // Contention, straight out of reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cont_rdy0", req0_ready, !exp_g1[i]);
            check("cont_rdy1", req1_ready, exp_g1[i]);
            if (exp_g1[i]) push(3'd2, 16'h2222);
            else push(3'd1, 16'h1111);
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("idle_rdy0", req0_ready, 0);
        check("idle_rdy1", req1_ready, 0);
        check("idle_wr_last", wr_en, 1);
        next_cycle();
        @(negedge clk);
        check("idle_wr_en", wr_en, 0);
        next_cycle();

        // Single write with hazard on rd0
        iss_valid = 1'b1; iss_addr = 3'd3; rd0_addr = 3'd3;
        @(negedge clk);
        check("sw_t0_hazard", hazard, 0);
        next_cycle();
        iss_valid = 1'b0;
        @(negedge clk);
        check("sw_t1_busy", busy, 8'h08);
        check("sw_t1_hazard", hazard, 1);
        next_cycle();
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
        @(negedge clk);
        check("sw_t2_rdy0", req0_ready, 1);
        check("sw_t2_hazard", hazard, 1);
        push(3'd3, 16'hBEEF);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        check("sw_t3_wr_en", wr_en, 1);
        check("sw_t3_busy", busy, 8'h08);
        check("sw_t3_hazard", hazard, 1);
        next_cycle();
        @(negedge clk);
        check("sw_t4_busy", busy, 0);
        check("sw_t4_hazard", hazard, 0);
        check("sw_t4_wr_en", wr_en, 0);
        next_cycle();
        rd0_addr = 3'd0;

        // Set/clear collision on reg 5
        iss_valid = 1'b1; iss_addr = 3'd5;
        next_cycle();
        iss_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'h5555;
        @(negedge clk);
        check("col_rdy1", req1_ready, 1);
        push(3'd5, 16'h5555);
        next_cycle();
        req1_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 3'd5;
        @(negedge clk);
        check("col_wr_en", wr_en, 1);
        next_cycle();
        iss_valid = 1'b0;
        @(negedge clk);
        check("col_busy", busy, 8'h20);
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'hA5A5;
        push(3'd5, 16'hA5A5);
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("col_busy_clr", busy, 0);
        next_cycle();

        // Dual-read hazard on reg 7
        iss_valid = 1'b1; iss_addr = 3'd7;
        next_cycle();
        iss_valid = 1'b0;
        rd0_addr = 3'd0; rd1_addr = 3'd7;
        @(negedge clk);
        check("dr_busy", busy, 8'h80);
        check("dr_hazard7", hazard, 1);
        #1 rd1_addr = 3'd6;
        #1 check("dr_hazard6", hazard, 0);
        next_cycle();
        req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 16'h7777;
        push(3'd7, 16'h7777);
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("dr_busy_clr", busy, 0);
        next_cycle();

        // Reset the cycle after a grant drops the write
        iss_valid = 1'b1; iss_addr = 3'd2;
        next_cycle();
        iss_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 16'h2A2A;
        @(negedge clk);
        check("rm_rdy0", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rm_wr_en_rst", wr_en, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rm_wr_en", wr_en, 0);
        check("rm_busy", busy, 0);
        check("rm_hazard", hazard, 0);
        next_cycle();
        next_cycle();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the 8x16 register file between two writeback requesters: requester 0 is ALU writeback, requester 1 is load-return writeback.
- Keeps a per-register busy scoreboard: a register is marked busy when an instruction with that destination issues, and cleared when its write lands.
- Drives a read-hazard stall for the two read addresses.
- Sits between the issue/execute stages and the register file write port.

Parameters:
- DATA_W, 16, write data width.
- ADDR_W, 3, register address width.
- NREG, 8, number of registers, equal to 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- req1_ready  out  1  load request accepted this cycle.
- iss_valid  in  1  an instruction with a destination issues.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- rd0_addr  in  ADDR_W  read address 0, as presented to the register file.
- rd1_addr  in  ADDR_W  read address 1.
- hazard  out  1  a read address targets a busy register.
- wr_en  out  1  register file write enable.
- wr0_addr  out  ADDR_W  register file write address.
- wr0_data  out  DATA_W  register file write data.
- busy  out  NREG  scoreboard bit vector.

Behaviour:
- Reset, synchronous with rst=1:
  - wr_en=0, wr0_addr=0, wr0_data=0.
  - busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - rst overrides all same-cycle requests and issues; writes in flight are dropped.
- Arbitration (combinational):
  - Exactly one grant per cycle, and only to a valid requester.
  - reqN_ready = grantN.
  - A transfer occurs when valid & ready.
  - Requesters hold valid, addr and data stable until ready.
- Tie-breaking with both requesters valid:
  - Round robin: grant the requester that is not last_grant.
  - last_grant updates only on a transfer.
- Write stage: one register stage, so write latency is 1 cycle.
  - On a transfer: wr_en<=1, wr0_addr<=granted addr, wr0_data<=granted data.
  - Otherwise wr_en<=0 and addr/data hold their values.
  - The register file performs the write at the edge after the wr_en=1 cycle.
- Sustained throughput: one write per cycle; back-to-back grants allowed.
- Scoreboard, evaluated at each edge:
  - busy[iss_addr] sets if iss_valid.
  - busy[wr0_addr] clears if wr_en=1, i.e. at the edge where the register file actually writes.
  - Same address set and cleared in the same cycle: set wins (a newer write is pending).
  - Issue to an already-busy register: stays busy. Issue does not stall; ordering is the pipeline's responsibility.
- Hazard (combinational): hazard = busy[rd0_addr] | busy[rd1_addr].
  - Hazard deasserts the cycle after the write edge; a read in that cycle returns the new data.
- Both requesters targeting the same address in successive cycles: writes happen in grant order; the last granted write wins.
- No requests pending: grants=0, wr_en=0 next cycle, last_grant unchanged.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin tie-breaking as above.
- Undefined:
  - Fixed priority: requester 1 (load) always wins ties. A held requester 0 is only granted when req1_valid=0.
  - last_grant flop is absent.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, NREG constants.
  - Requester index constants REQ_ALU=0, REQ_LD=1.
  - A writeback request struct {addr, data}.
- One sub-module: wb_rr_arb, a 2-input arbiter taking valid[1:0] and returning a one-hot grant[1:0], with last_grant state inside.
- Scoreboard and write stage stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs active -> wr_en=0, busy=8'h00, hazard=0, both ready=0 during reset.
- Single write:
  - Stimulus: iss (addr 3) at T0; req0 valid (addr 3, data 16'hBEEF) at T2.
  - req0_ready=1 at T2; wr_en=1 with addr 3 and data BEEF at T3.
  - busy[3]=1 from T1 through the T3 edge, 0 after it.
  - rd0_addr=3 gives hazard=1 until T4, then 0.
- Contention:
  - Stimulus: both requesters valid continuously (req0 addr 1 data 0x1111, req1 addr 2 data 0x2222) for 4 cycles.
  - With WB_ROUND_ROBIN_EN: grants go 0,1,0,1.
  - Without the macro: grants go 1,1,1,1 and req0_ready stays 0.
- Set/clear collision: busy[5]=1, write to reg 5 lands in the same cycle as iss_addr=5 -> busy[5] stays 1.
- Dual-read hazard: busy=8'h80, rd0=0, rd1=7 -> hazard=1; rd1 changed to 6 -> hazard=0 in the same cycle.
- Reset mid-operation: rst asserted in the cycle after a grant -> wr_en=0 and busy=0 next cycle; no write issued.
